radix4_ctrl: RTL and testbench

RADIX4_CTRL -- requirements
Module: radix4_ctrl

---
 rtl/radix4_ctrl.sv | 86 ++++++++
 tb/tb_radix4_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/radix4_ctrl.sv
// radix4_ctrl: sequencing FSM for a radix-4 Booth multiplier datapath.
// Loads four operand bytes, then alternates ADD/SHIFT for NITER iterations.
module radix4_ctrl #(
  parameter int NITER = 8,
  parameter int NBYTES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_in_valid,
  input  logic [2:0] i_win,
  output logic       o_in_ready,
  output logic       o_clr,
  output logic       o_lda_m,
  output logic       o_lda_l,
  output logic       o_ldb_m,
  output logic       o_ldb_l,
  output logic       o_shen,
  output logic       o_lastbit,
  output logic       o_ldp,
  output logic [2:0] o_sel,
  output logic       o_ci,
  output logic       o_busy,
  output logic       o_done
);
  localparam int IW = NITER > 1 ? $clog2(NITER) : 1;
  localparam int BW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_ADD, S_SHIFT, S_DONE} state_t;
  state_t        r_state;
  logic [BW-1:0] r_bcnt;
  logic [IW-1:0] r_icnt;
  logic          w_acc;
  logic          w_add;
  logic          w_last_b;
  logic          w_last_i;
  logic [2:0]    w_sel;
  assign w_acc    = r_state == S_LOAD && i_in_valid;
  assign w_add    = r_state == S_ADD;
  assign w_last_b = r_bcnt == BW'(NBYTES - 1);
  assign w_last_i = r_icnt == IW'(NITER - 1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_icnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) r_state <= S_CLR;
        S_CLR: begin
          r_bcnt  <= '0;
          r_icnt  <= '0;
          r_state <= S_LOAD;
        end
        S_LOAD:  if (i_in_valid) begin
          if (w_last_b) r_state <= S_ADD;
          else r_bcnt <= r_bcnt + 1'b1;
        end
        S_ADD:   r_state <= S_SHIFT;
        S_SHIFT: begin
          r_state <= w_last_i ? S_DONE : S_ADD;
          if (!w_last_i) r_icnt <= r_icnt + 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // Booth recoding: 0, +M, +2M, -2M (sel 3), -M (sel 4); negatives add via ~M + 1.
  assign w_sel = (i_win == 3'b000 || i_win == 3'b111) ? 3'd0 :
                 (i_win == 3'b001 || i_win == 3'b010) ? 3'd1 :
                 (i_win == 3'b011) ? 3'd2 :
                 (i_win == 3'b100) ? 3'd3 : 3'd4;
  assign o_sel      = w_add ? w_sel : 3'd0;
  assign o_ci       = w_add && i_win[2] && !(&i_win);
  assign o_ldp      = w_add;
  assign o_in_ready = r_state == S_LOAD;
  assign o_clr      = r_state == S_CLR;
  assign o_lastbit  = r_state == S_CLR;
  assign o_lda_m    = w_acc && r_bcnt == BW'(0);
  assign o_lda_l    = w_acc && r_bcnt == BW'(1);
  assign o_ldb_m    = w_acc && r_bcnt == BW'(2);
  assign o_ldb_l    = w_acc && r_bcnt == BW'(3);
  assign o_shen     = r_state == S_SHIFT;
  assign o_busy     = r_state != S_IDLE;
  assign o_done     = r_state == S_DONE;
endmodule

// File: tb/tb_radix4_ctrl.sv
// tb_radix4_ctrl: directed and randomized checks of radix4_ctrl against a
// per-cycle phase model and an arithmetic Booth-digit decode reference.
module tb_radix4_ctrl;
  localparam int K_IDLE = 0, K_CLR = 1, K_LOAD = 2, K_ADD = 3, K_SHIFT = 4, K_DONE = 5;
  logic       clk, rst_n, start, in_valid;
  logic [2:0] win;
  logic       in_ready, clr, lda_m, lda_l, ldb_m, ldb_l, shen, lastbit, ldp, ci, busy, done;
  logic [2:0] sel;
  logic [14:0] obs;
  int checks = 0;
  int failures = 0;

  radix4_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_in_valid(in_valid), .i_win(win),
    .o_in_ready(in_ready), .o_clr(clr), .o_lda_m(lda_m), .o_lda_l(lda_l),
    .o_ldb_m(ldb_m), .o_ldb_l(ldb_l), .o_shen(shen), .o_lastbit(lastbit),
    .o_ldp(ldp), .o_sel(sel), .o_ci(ci), .o_busy(busy), .o_done(done)
  );

  assign obs = {in_ready, clr, lda_m, lda_l, ldb_m, ldb_l, shen, lastbit, ldp, sel, ci, busy, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one cycle of a given phase; ADD derives sel/ci from the Booth digit value.
  function automatic logic [14:0] vec(input int k, input int a);
    logic [14:0] v;
    int d;
    v = '0;
    v[1] = k != K_IDLE;
    if (k == K_CLR) begin v[13] = 1'b1; v[7] = 1'b1; end
    if (k == K_LOAD) begin v[14] = 1'b1; if (a >= 0) v[12 - a] = 1'b1; end
    if (k == K_SHIFT) v[8] = 1'b1;
    if (k == K_DONE) v[0] = 1'b1;
    if (k == K_ADD) begin
      d = a[1] + a[0] - 2 * a[2];
      v[6] = 1'b1;
      v[5:3] = d == 0 ? 3'd0 : d > 0 ? 3'(d) : d == -2 ? 3'd3 : 3'd4;
      v[2] = d < 0;
    end
    return v;
  endfunction

  task automatic cyc(input int k, input int a, input string tag);
    logic [14:0] e;
    e = vec(k, a);
    @(negedge clk);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  // lmode: 0 back-to-back bytes, 1 fixed gapped pattern, 2 random gaps.
  // wmode: 0 fixed window, 1 sweep by iteration, 2 random.
  task automatic run(input int lmode, input int wmode, input logic [2:0] wfix,
                     input int start_it, input int abort_it);
    logic [6:0] pat;
    int n, p, g;
    pat = 7'b1011001;
    n = 0; p = 0; g = 0;
    start = 1'b1;
    cyc(K_IDLE, 0, "idle_start");
    start = 1'b0;
    in_valid = 1'($urandom_range(0, 1));
    cyc(K_CLR, 0, "clr");
    while (n < 4) begin
      in_valid = lmode == 0 ? 1'b1 : lmode == 1 ? pat[p] : (g >= 3 ? 1'b1 : 1'($urandom_range(0, 1)));
      p++;
      g = in_valid ? 0 : g + 1;
      cyc(K_LOAD, in_valid ? n : -1, "load");
      if (in_valid) n++;
    end
    for (int it = 0; it < 8; it++) begin
      in_valid = 1'($urandom_range(0, 1));
      win = wmode == 0 ? wfix : wmode == 1 ? 3'(it) : 3'($urandom_range(0, 7));
      start = it == start_it;
      cyc(K_ADD, int'(win), "add");
      start = 1'b0;
      win = 3'($urandom_range(0, 7));
      if (it == abort_it) begin
        #2 rst_n = 1'b0;
        cyc(K_IDLE, 0, "rst_async");
        cyc(K_IDLE, 0, "rst_hold");
        rst_n = 1'b1;
        in_valid = 1'b0;
        cyc(K_IDLE, 0, "rst_nodone");
        cyc(K_IDLE, 0, "rst_nodone2");
        return;
      end
      cyc(K_SHIFT, 0, "shift");
    end
    in_valid = 1'b0;
    cyc(K_DONE, 0, "done");
    cyc(K_IDLE, 0, "idle_after");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; win = 3'd0;
    cyc(K_IDLE, 0, "reset");
    cyc(K_IDLE, 0, "reset2");
    rst_n = 1'b1;
    cyc(K_IDLE, 0, "idle");
    run(0, 0, 3'b011, -1, -1);
    run(0, 1, 3'b000, -1, -1);
    run(1, 2, 3'b000, -1, -1);
    run(0, 2, 3'b000, 2, -1);
    run(0, 2, 3'b000, -1, 5);
    run(0, 0, 3'b011, -1, -1);
    in_valid = 1'b1;
    cyc(K_IDLE, 0, "stray");
    cyc(K_IDLE, 0, "stray2");
    run(0, 2, 3'b000, -1, -1);
    for (int r = 0; r < 4; r++) run(2, 2, 3'b000, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
